enm_bullet_pool: RTL and testbench

//  Parametrised enemy bullet engine: N_ENM enemies, each owning N_DIR bullet slots (one per fan direction).
//  Per-enemy FSM auto-fires volleys on a cooldown, bullets advance on a movement tick, and the block clears

---
 rtl/enm_bullet_pool.sv | 191 +++++++++++++++++++
 tb/tb_enm_bullet_pool.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enm_bullet_pool.sv
// enm_bullet_pool: N_ENM enemies x N_DIR fan slots; auto-fire, move, clip, hit detect.
// In: clk22, rst_n, tick, enm_alive/x/y, reimux/y, invuln, dir_en. Out: bullet_v/x/y, hit, hit_cnt.
module enm_bullet_pool #(
  parameter int N_ENM       = 4,
  parameter int N_DIR       = 3,
  parameter int W           = 10,
  parameter int SPEED_V     = 10,
  parameter int SPEED_D     = 7,
  parameter int FIRE_PERIOD = 16,
  parameter int XMIN        = 8,
  parameter int XMAX        = 432,
  parameter int YMIN        = 8,
  parameter int YMAX        = 472,
  parameter int HIT_L       = 10,
  parameter int HIT_R       = 12,
  parameter int HIT_Y       = 11
) (
  input  logic                     clk22,
  input  logic                     rst_n,
  input  logic                     tick,
  input  logic [N_ENM-1:0]         enm_alive,
  input  logic [N_ENM*W-1:0]       enm_x,
  input  logic [N_ENM*W-1:0]       enm_y,
  input  logic [W-1:0]             reimux,
  input  logic [W-1:0]             reimuy,
  input  logic                     invuln,
  input  logic [N_DIR-1:0]         dir_en,
  output logic [N_ENM*N_DIR-1:0]   bullet_v,
  output logic [N_ENM*N_DIR*W-1:0] bullet_x,
  output logic [N_ENM*N_DIR*W-1:0] bullet_y,
  output logic                     hit,
  output logic [7:0]               hit_cnt
);

  localparam int NS   = N_ENM * N_DIR;
  localparam int CW   = $clog2(FIRE_PERIOD);
  localparam int HALF = (N_DIR - 1) / 2;

  typedef logic signed [W+1:0] sw_t;
  typedef enum logic [1:0] {IDLE, COOL, FIRE} st_e;

  st_e           st_q  [N_ENM];
  st_e           st_d  [N_ENM];
  logic [CW-1:0] cnt_q [N_ENM];
  logic [CW-1:0] cnt_d [N_ENM];
  logic [N_ENM-1:0] fire;

  logic [NS-1:0] v_q, v_d;
  logic [NS-1:0] in_box, out_f;
  logic [W-1:0]  x_q [NS];
  logic [W-1:0]  x_d [NS];
  logic [W-1:0]  y_q [NS];
  logic [W-1:0]  y_d [NS];
  sw_t           bx  [NS];
  sw_t           by  [NS];
  sw_t           nx  [NS];
  sw_t           ny  [NS];

  logic       any_hit;
  logic       hit_q, hit_d;
  logic [7:0] hit_cnt_q, hit_cnt_d;
  sw_t        px, py;

  // Widened signed so the hitbox edges and step results never wrap.
  assign px = sw_t'({2'b00, reimux});
  assign py = sw_t'({2'b00, reimuy});

  always_comb begin
    for (int e = 0; e < N_ENM; e++) begin
      st_d[e]  = st_q[e];
      cnt_d[e] = cnt_q[e];
      fire[e]  = 1'b0;
      if (!enm_alive[e]) begin
        st_d[e]  = IDLE;
        cnt_d[e] = '0;
      end else if (tick) begin
        unique case (st_q[e])
          IDLE: begin
            st_d[e]  = COOL;
            cnt_d[e] = CW'(FIRE_PERIOD - 1);
          end
          COOL: begin
            if (cnt_q[e] == '0) st_d[e] = FIRE;
            else cnt_d[e] = cnt_q[e] - 1'b1;
          end
          FIRE: begin
            fire[e]  = 1'b1;
            cnt_d[e] = CW'(FIRE_PERIOD - 1);
            st_d[e]  = COOL;
          end
          default: st_d[e] = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    for (int s = 0; s < NS; s++) begin
      bx[s] = sw_t'({2'b00, x_q[s]});
      by[s] = sw_t'({2'b00, y_q[s]});
      nx[s] = bx[s] + sw_t'((s % N_DIR - HALF) * SPEED_D);
      ny[s] = by[s] + sw_t'(((s % N_DIR) == HALF) ? SPEED_V : SPEED_D);
      in_box[s] = (px - sw_t'(HIT_L) < bx[s]) &&
                  (bx[s] < px + sw_t'(HIT_R)) &&
                  (py - sw_t'(HIT_Y) < by[s]) &&
                  (by[s] < py + sw_t'(HIT_Y));
      out_f[s]  = (nx[s] < sw_t'(XMIN)) ||
                  (nx[s] > sw_t'(XMAX)) ||
                  (ny[s] < sw_t'(YMIN)) ||
                  (ny[s] > sw_t'(YMAX));
    end
  end

  // Hit test uses the pre-move position; a freshly spawned slot
  // skips both hit and move on its spawn tick.
  always_comb begin
    any_hit = 1'b0;
    for (int s = 0; s < NS; s++) begin
      v_d[s] = v_q[s];
      x_d[s] = x_q[s];
      y_d[s] = y_q[s];
      if (!enm_alive[s / N_DIR]) begin
        v_d[s] = 1'b0;
        x_d[s] = '0;
        y_d[s] = '0;
      end else if (tick) begin
        if (v_q[s]) begin
          if (in_box[s] && !invuln) begin
            v_d[s]  = 1'b0;
            any_hit = 1'b1;
          end else if (out_f[s]) begin
            v_d[s] = 1'b0;
          end else begin
            x_d[s] = nx[s][W-1:0];
            y_d[s] = ny[s][W-1:0];
          end
        end else if (fire[s / N_DIR] && dir_en[s % N_DIR]) begin
          v_d[s] = 1'b1;
          x_d[s] = enm_x[(s / N_DIR) * W +: W];
          y_d[s] = enm_y[(s / N_DIR) * W +: W];
        end
      end
    end
  end

  always_comb begin
    hit_d     = any_hit;
    hit_cnt_d = hit_cnt_q;
    if (any_hit && hit_cnt_q != 8'hFF) hit_cnt_d = hit_cnt_q + 8'd1;
  end

  always_ff @(posedge clk22 or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < N_ENM; e++) begin
        st_q[e]  <= IDLE;
        cnt_q[e] <= '0;
      end
      for (int s = 0; s < NS; s++) begin
        x_q[s] <= '0;
        y_q[s] <= '0;
      end
      v_q       <= '0;
      hit_q     <= 1'b0;
      hit_cnt_q <= '0;
    end else begin
      for (int e = 0; e < N_ENM; e++) begin
        st_q[e]  <= st_d[e];
        cnt_q[e] <= cnt_d[e];
      end
      for (int s = 0; s < NS; s++) begin
        x_q[s] <= x_d[s];
        y_q[s] <= y_d[s];
      end
      v_q       <= v_d;
      hit_q     <= hit_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  always_comb begin
    for (int s = 0; s < NS; s++) begin
      bullet_x[s*W +: W] = x_q[s];
      bullet_y[s*W +: W] = y_q[s];
    end
  end

  assign bullet_v = v_q;
  assign hit      = hit_q;
  assign hit_cnt  = hit_cnt_q;

endmodule

// File: tb/tb_enm_bullet_pool.sv
// tb_enm_bullet_pool: directed scenarios plus random traffic for enm_bullet_pool,
// checked every cycle against an integer-arithmetic reference model.
module tb_enm_bullet_pool;

  localparam int NE = 4, ND = 3, W = 10, NS = NE * ND, FP = 16;
  localparam int SV = 10, SD = 7;
  localparam int XMIN = 8, XMAX = 432, YMIN = 8, YMAX = 472;
  localparam int HL = 10, HR = 12, HY = 11;
  localparam int OW = NS + 2 * NS * W + 9;

  logic clk22 = 1'b0, rst_n = 1'b0, tick = 1'b0, invuln = 1'b0;
  logic [NE-1:0]   enm_alive = '0;
  logic [NE*W-1:0] enm_x = '0, enm_y = '0;
  logic [W-1:0]    reimux = '0, reimuy = '0;
  logic [ND-1:0]   dir_en = '0;
  logic [NS-1:0]   bullet_v;
  logic [NS*W-1:0] bullet_x, bullet_y;
  logic            hit;
  logic [7:0]      hit_cnt;
  wire  [OW-1:0]   obs = {bullet_v, bullet_x, bullet_y, hit, hit_cnt};

  int ncmp = 0, nerr = 0;

  always #5 clk22 = ~clk22;

  enm_bullet_pool dut (
    .clk22(clk22), .rst_n(rst_n), .tick(tick),
    .enm_alive(enm_alive), .enm_x(enm_x), .enm_y(enm_y),
    .reimux(reimux), .reimuy(reimuy), .invuln(invuln), .dir_en(dir_en),
    .bullet_v(bullet_v), .bullet_x(bullet_x), .bullet_y(bullet_y),
    .hit(hit), .hit_cnt(hit_cnt)
  );

  // Reference model: an enemy volleys on every (FP+1)-th tick after
  // the tick that activated it; bullets are plain integers.
  bit m_v [NS];
  int m_x [NS];
  int m_y [NS];
  bit m_act [NE];
  int m_age [NE];
  bit m_hit;
  int m_cnt;

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      m_v[s] = 0; m_x[s] = 0; m_y[s] = 0;
    end
    for (int e = 0; e < NE; e++) begin
      m_act[e] = 0; m_age[e] = 0;
    end
    m_hit = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    bit fire [NE];
    bit any;
    int e, d, nx, ny, px, py;
    any = 0;
    px = int'(reimux);
    py = int'(reimuy);
    for (int k = 0; k < NE; k++) begin
      fire[k] = 0;
      if (!enm_alive[k]) m_act[k] = 0;
      else if (tick) begin
        if (!m_act[k]) begin
          m_act[k] = 1; m_age[k] = 0;
        end else begin
          m_age[k]++;
          fire[k] = (m_age[k] % (FP + 1)) == 0;
        end
      end
    end
    for (int s = 0; s < NS; s++) begin
      e = s / ND; d = s % ND;
      if (!enm_alive[e]) begin
        m_v[s] = 0; m_x[s] = 0; m_y[s] = 0;
      end else if (tick) begin
        if (m_v[s]) begin
          if (!invuln && px - HL < m_x[s] && m_x[s] < px + HR &&
              py - HY < m_y[s] && m_y[s] < py + HY) begin
            m_v[s] = 0; any = 1;
          end else begin
            nx = m_x[s] + (d - (ND - 1) / 2) * SD;
            ny = m_y[s] + ((d == (ND - 1) / 2) ? SV : SD);
            if (nx < XMIN || nx > XMAX || ny < YMIN || ny > YMAX) m_v[s] = 0;
            else begin
              m_x[s] = nx; m_y[s] = ny;
            end
          end
        end else if (fire[e] && dir_en[d]) begin
          m_v[s] = 1;
          m_x[s] = int'(enm_x[e*W +: W]);
          m_y[s] = int'(enm_y[e*W +: W]);
        end
      end
    end
    m_hit = any;
    if (any && m_cnt < 255) m_cnt++;
  endtask

  function automatic logic [OW-1:0] exp_all();
    logic [NS-1:0]   v;
    logic [NS*W-1:0] x, y;
    for (int s = 0; s < NS; s++) begin
      v[s] = m_v[s];
      x[s*W +: W] = W'(m_x[s]);
      y[s*W +: W] = W'(m_y[s]);
    end
    return {v, x, y, m_hit, 8'(m_cnt)};
  endfunction

  task automatic set_enm(input int e, input int x, input int y);
    enm_x[e*W +: W] = W'(x);
    enm_y[e*W +: W] = W'(y);
  endtask

  task automatic cyc(input logic t);
    tick = t;
    model_step();
    @(posedge clk22);
    #1;
    tick = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick = 1'b0; invuln = 1'b0;
    enm_alive = '0; dir_en = '0;
    enm_x = '0; enm_y = '0; reimux = '0; reimuy = '0;
    model_reset();
    repeat (2) @(posedge clk22);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    ncmp++;
    if (obs !== '0) begin
      nerr++; $display("FAIL reset_hold got=%h exp=0", obs);
    end
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1);
      ncmp++;
      if (obs !== '0) begin
        nerr++; $display("FAIL reset_idle c%0d got=%h exp=0", i, obs);
      end
    end
  endtask

  task automatic test_volley();
    int ex[3] = '{193, 200, 207};
    int ey[3] = '{107, 110, 107};
    do_reset();
    set_enm(0, 200, 100);
    dir_en = 3'b111; reimux = 10'd1000; reimuy = 10'd1000;
    enm_alive = 4'b0001;
    for (int i = 0; i < 36; i++) begin
      cyc(i % 2 == 0);
      ncmp++;
      if (obs !== exp_all()) begin
        nerr++; $display("FAIL volley c%0d got=%h exp=%h", i, obs, exp_all());
      end
      if (i == 33) begin
        ncmp++;
        if (bullet_v !== '0) begin
          nerr++; $display("FAIL volley_early v=%h exp=0", bullet_v);
        end
      end
    end
    for (int d = 0; d < 3; d++) begin
      ncmp++;
      if (bullet_v[d] !== 1'b1 || bullet_x[d*W +: W] !== 10'd200 ||
          bullet_y[d*W +: W] !== 10'd100) begin
        nerr++;
        $display("FAIL volley_spawn d%0d v=%b x=%0d y=%0d exp 1,200,100",
                 d, bullet_v[d], bullet_x[d*W +: W], bullet_y[d*W +: W]);
      end
    end
    cyc(1'b1);
    for (int d = 0; d < 3; d++) begin
      ncmp++;
      if (bullet_v[d] !== 1'b1 || int'(bullet_x[d*W +: W]) != ex[d] ||
          int'(bullet_y[d*W +: W]) != ey[d]) begin
        nerr++;
        $display("FAIL volley_move d%0d v=%b x=%0d y=%0d exp 1,%0d,%0d",
                 d, bullet_v[d], bullet_x[d*W +: W], bullet_y[d*W +: W], ex[d], ey[d]);
      end
    end
  endtask

  task automatic test_exit();
    int ci[5] = '{17, 18, 19, 20, 34};
    bit cv[5] = '{1, 1, 1, 0, 1};
    int cy[5] = '{450, 460, 470, 470, 450};
    do_reset();
    set_enm(0, 200, 450);
    dir_en = 3'b010; reimux = 10'd1000; reimuy = 10'd1000;
    enm_alive = 4'b0001;
    for (int i = 0; i < 35; i++) begin
      cyc(1'b1);
      ncmp++;
      if (obs !== exp_all()) begin
        nerr++; $display("FAIL exit c%0d got=%h exp=%h", i, obs, exp_all());
      end
      for (int k = 0; k < 5; k++) begin
        if (i == ci[k]) begin
          ncmp++;
          if (bullet_v[1] !== cv[k] || int'(bullet_y[W +: W]) != cy[k] ||
              bullet_x[W +: W] !== 10'd200) begin
            nerr++;
            $display("FAIL exit_pt t%0d v=%b x=%0d y=%0d exp %0d,200,%0d",
                     i, bullet_v[1], bullet_x[W +: W], bullet_y[W +: W], cv[k], cy[k]);
          end
        end
      end
    end
  endtask

  task automatic test_hit();
    int ci[5] = '{18, 19, 20, 36, 37};
    bit cv[5] = '{1, 0, 0, 1, 1};
    int cy[5] = '{120, 120, 120, 130, 140};
    bit ch[5] = '{0, 1, 0, 0, 0};
    int cc[5] = '{0, 1, 1, 1, 1};
    do_reset();
    set_enm(0, 200, 110);
    dir_en = 3'b010; reimux = 10'd200; reimuy = 10'd130;
    enm_alive = 4'b0001;
    for (int i = 0; i < 38; i++) begin
      invuln = (i >= 21);
      cyc(1'b1);
      ncmp++;
      if (obs !== exp_all()) begin
        nerr++; $display("FAIL hit c%0d got=%h exp=%h", i, obs, exp_all());
      end
      for (int k = 0; k < 5; k++) begin
        if (i == ci[k]) begin
          ncmp++;
          if (bullet_v[1] !== cv[k] || int'(bullet_y[W +: W]) != cy[k] ||
              hit !== ch[k] || int'(hit_cnt) != cc[k]) begin
            nerr++;
            $display("FAIL hit_pt t%0d v=%b y=%0d hit=%b cnt=%0d exp %0d,%0d,%0d,%0d",
                     i, bullet_v[1], bullet_y[W +: W], hit, hit_cnt, cv[k], cy[k], ch[k], cc[k]);
          end
        end
      end
    end
  endtask

  task automatic test_multi_hit();
    do_reset();
    set_enm(0, 200, 110);
    set_enm(3, 200, 110);
    dir_en = 3'b010; reimux = 10'd200; reimuy = 10'd130;
    enm_alive = 4'b1001;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1);
      ncmp++;
      if (obs !== exp_all()) begin
        nerr++; $display("FAIL multi c%0d got=%h exp=%h", i, obs, exp_all());
      end
    end
    ncmp++;
    if (bullet_v !== '0 || hit !== 1'b1 || hit_cnt !== 8'd1) begin
      nerr++;
      $display("FAIL multi_pulse v=%h hit=%b cnt=%0d exp 0,1,1", bullet_v, hit, hit_cnt);
    end
    rst_n = 1'b0;
    #1;
    ncmp++;
    if (obs !== '0) begin
      nerr++; $display("FAIL reset_async_pulse got=%h exp=0", obs);
    end
    model_reset();
    @(posedge clk22);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_underflow();
    do_reset();
    set_enm(0, 12, 100);
    set_enm(1, 3, 200);
    dir_en = 3'b001; reimux = 10'd1000; reimuy = 10'd1000;
    enm_alive = 4'b0011;
    for (int i = 0; i < 19; i++) begin
      cyc(1'b1);
      ncmp++;
      if (obs !== exp_all()) begin
        nerr++; $display("FAIL under c%0d got=%h exp=%h", i, obs, exp_all());
      end
      if (i == 17 || i == 18) begin
        ncmp++;
        if (bullet_v[0] !== (i == 17) || bullet_v[3] !== (i == 17) ||
            bullet_x[0 +: W] !== 10'd12 || bullet_x[3*W +: W] !== 10'd3) begin
          nerr++;
          $display("FAIL under_pt t%0d v0=%b x0=%0d v3=%b x3=%0d exp v=%0d x 12/3",
                   i, bullet_v[0], bullet_x[0 +: W], bullet_v[3], bullet_x[3*W +: W], i == 17);
        end
      end
    end
  endtask

  task automatic test_death_reset();
    do_reset();
    set_enm(0, 100, 100);
    set_enm(1, 300, 100);
    dir_en = 3'b111; reimux = 10'd1000; reimuy = 10'd1000;
    enm_alive = 4'b0011;
    for (int i = 0; i < 20; i++) cyc(1'b1);
    enm_alive = 4'b0001;
    cyc(1'b0);
    ncmp++;
    if (obs !== exp_all()) begin
      nerr++; $display("FAIL death got=%h exp=%h", obs, exp_all());
    end
    ncmp++;
    if (bullet_v[5:3] !== 3'b000 || bullet_v[2:0] !== 3'b111 ||
        bullet_x[3*W +: 3*W] !== '0 || bullet_y[3*W +: 3*W] !== '0) begin
      nerr++;
      $display("FAIL death_clear v=%h x=%h y=%h exp v 007 x/y hi 0",
               bullet_v, bullet_x[3*W +: 3*W], bullet_y[3*W +: 3*W]);
    end
    cyc(1'b1);
    cyc(1'b1);
    rst_n = 1'b0;
    #1;
    ncmp++;
    if (obs !== '0) begin
      nerr++; $display("FAIL reset_async got=%h exp=0", obs);
    end
    model_reset();
    @(posedge clk22);
    #1;
    ncmp++;
    if (obs !== '0) begin
      nerr++; $display("FAIL reset_async_hold got=%h exp=0", obs);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_saturate();
    do_reset();
    for (int e = 0; e < NE; e++) set_enm(e, 200, 200);
    dir_en = 3'b111; reimux = 10'd200; reimuy = 10'd200;
    enm_alive = 4'b1111;
    for (int i = 0; i < 4500; i++) begin
      cyc(1'b1);
      ncmp++;
      if (obs !== exp_all()) begin
        nerr++; $display("FAIL sat c%0d got=%h exp=%h", i, obs, exp_all());
      end
    end
    ncmp++;
    if (hit_cnt !== 8'd255) begin
      nerr++; $display("FAIL sat_cnt got=%0d exp=255", hit_cnt);
    end
  endtask

  task automatic test_random();
    int k, v;
    do_reset();
    enm_alive = 4'b1111;
    for (int e = 0; e < NE; e++) set_enm(e, $urandom_range(XMIN, XMAX), $urandom_range(YMIN, 300));
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 31) == 0) begin
        k = $urandom_range(0, NE - 1);
        enm_alive[k] = ~enm_alive[k];
      end
      for (int e = 0; e < NE; e++) begin
        if ($urandom_range(0, 15) == 0) begin
          if ($urandom_range(0, 1) == 1)
            set_enm(e, $urandom_range(XMIN, XMAX), $urandom_range(YMIN, YMAX));
          else
            set_enm(e, $urandom_range(0, 1023), $urandom_range(0, 1023));
        end
      end
      if (i % 8 == 0) begin
        k = $urandom_range(0, NE - 1);
        v = int'(enm_x[k*W +: W]) + int'($urandom_range(0, 30)) - 15;
        reimux = W'((v < 0) ? 0 : (v > 1023) ? 1023 : v);
        v = int'(enm_y[k*W +: W]) + int'($urandom_range(0, 40));
        reimuy = W'((v > 1023) ? 1023 : v);
      end
      dir_en = ND'($urandom_range(0, 7));
      invuln = ($urandom_range(0, 4) == 0);
      cyc($urandom_range(0, 1) == 1);
      ncmp++;
      if (obs !== exp_all()) begin
        nerr++; $display("FAIL random c%0d got=%h exp=%h", i, obs, exp_all());
      end
    end
  endtask

  initial begin
    test_reset();
    test_volley();
    test_exit();
    test_hit();
    test_multi_hit();
    test_underflow();
    test_death_reset();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
